// File: rtl/ff_bank_arbiter_if.sv
// Requester-side bus of the flip-flop bank arbiter: requests, addresses, data, grants, status and bank contents.
// Latency: none, this is wiring only.
// Backpressure: a requester holds req/addr/data stable until it sees its gnt bit.
interface ff_bank_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int AW       = $clog2(NUM_REGS)
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*AW-1:0]     wr_addr;
  logic [NUM_REQ*WIDTH-1:0]  wr_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      busy;
  logic                      wr_done;
  logic                      err;
  logic [NUM_REGS*WIDTH-1:0] q;

  // requester logic drives the requests and observes the results
  modport master (
    output req, wr_addr, wr_data,
    input  gnt, busy, wr_done, err, q
  );

  // arbiter side
  modport slave (
    input  req, wr_addr, wr_data,
    output gnt, busy, wr_done, err, q
  );
endinterface

// File: rtl/ff_bank_arbiter.sv
// Round-robin write arbiter feeding a bank of NUM_REGS x WIDTH flip-flop registers.
// Latency: grant one cycle after req is sampled; register written and wr_done/err pulsed one cycle later.
// Backpressure: one write per two cycles; ungranted requesters hold req, req changes during COMMIT are ignored.
module ff_bank_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input logic             clk,
  input logic             async_reset,
  ff_bank_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_REQ);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] COMMIT = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic [PW-1:0]             win_q, win_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [WIDTH-1:0]          data_q, data_d;
  logic [NUM_REGS*WIDTH-1:0] q_q, q_d;
  logic                      wr_done_q, wr_done_d;
  logic                      err_q, err_d;

  logic                      found;
  int                        sel;
  logic                      addr_ok;

  // round-robin search from ptr upward, wrapping; first requester found wins
  always_comb begin
    found = 1'b0;
    sel   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req[(int'(ptr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        sel   = (int'(ptr_q) + i) % NUM_REQ;
      end
    end
  end

  // staged address decode: only addresses that name a real register are valid
  always_comb begin
    addr_ok = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (addr_q == AW'(r)) addr_ok = 1'b1;
    end
  end

  // two-state sequencer: capture the winner in IDLE, write the bank in COMMIT
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    q_d       = q_q;
    wr_done_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          win_d      = PW'(sel);
          gnt_d[sel] = 1'b1;
          addr_d     = bus.wr_addr[sel*AW +: AW];
          data_d     = bus.wr_data[sel*WIDTH +: WIDTH];
          state_d    = COMMIT;
        end
      end
      COMMIT: begin
        // out-of-range addresses still consume the grant and advance the pointer
        if (addr_ok) begin
          for (int r = 0; r < NUM_REGS; r++) begin
            if (addr_q == AW'(r)) q_d[r*WIDTH +: WIDTH] = data_q;
          end
          wr_done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        ptr_d   = PW'((int'(win_q) + 1) % NUM_REQ);
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // state, staging and bank flops; reset aborts any in-flight write
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      q_q       <= '0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      q_q       <= q_d;
      wr_done_q <= wr_done_d;
      err_q     <= err_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q == COMMIT);
  assign bus.wr_done = wr_done_q;
  assign bus.err     = err_q;
  assign bus.q       = q_q;

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Directed bench for ff_bank_arbiter: vector table for single write, round-robin, wrap, withdrawal, late data change.
// Hand sequences cover out-of-range addressing (NUM_REGS=3) and asynchronous reset mid-commit.
// Inputs change and outputs are compared on the falling clock edge.
module tb_ff_bank_arbiter;

  logic clk;
  logic async_reset;

  int checks;
  int failures;

  ff_bank_arbiter_if #(.NUM_REQ(4), .WIDTH(8), .NUM_REGS(4)) bus ();
  ff_bank_arbiter_if #(.NUM_REQ(4), .WIDTH(8), .NUM_REGS(3)) bus3 ();

  ff_bank_arbiter #(.NUM_REQ(4), .WIDTH(8), .NUM_REGS(4)) dut (
    .clk         (clk),
    .async_reset (async_reset),
    .bus         (bus.slave)
  );

  ff_bank_arbiter #(.NUM_REQ(4), .WIDTH(8), .NUM_REGS(3)) dut3 (
    .clk         (clk),
    .async_reset (async_reset),
    .bus         (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [31:0] q;
  } vec_t;

  vec_t tv [26];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive4(input logic [3:0] r, input logic [7:0] a, input logic [31:0] d);
    bus.req     = r;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic drive3(input logic [3:0] r, input logic [7:0] a, input logic [31:0] d);
    bus3.req     = r;
    bus3.wr_addr = a;
    bus3.wr_data = d;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk3(input string name, input logic [3:0] g, input logic b, input logic dn,
                      input logic e, input logic [23:0] qq);
    chk({name, ".gnt"},     64'(bus3.gnt),     64'(g));
    chk({name, ".busy"},    64'(bus3.busy),    64'(b));
    chk({name, ".wr_done"}, 64'(bus3.wr_done), 64'(dn));
    chk({name, ".err"},     64'(bus3.err),     64'(e));
    chk({name, ".q"},       64'(bus3.q),       64'(qq));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;

    // single write, then a requester-3 write that brings the pointer back to 0
    tv[0]  = '{4'b0001, 8'h03, 32'h0000003C, 4'b0001, 1'b1, 1'b0, 32'h00000000};
    tv[1]  = '{4'b0000, 8'h03, 32'h0000003C, 4'b0000, 1'b0, 1'b1, 32'h3C000000};
    tv[2]  = '{4'b1000, 8'h40, 32'h5A000000, 4'b1000, 1'b1, 1'b0, 32'h3C000000};
    tv[3]  = '{4'b0000, 8'h40, 32'h5A000000, 4'b0000, 1'b0, 1'b1, 32'h3C005A00};
    // all four requesting: grants rotate 0,1,2,3,0
    tv[4]  = '{4'b1111, 8'hE4, 32'h44332211, 4'b0001, 1'b1, 1'b0, 32'h3C005A00};
    tv[5]  = '{4'b1111, 8'hE4, 32'h44332211, 4'b0000, 1'b0, 1'b1, 32'h3C005A11};
    tv[6]  = '{4'b1111, 8'hE4, 32'h44332211, 4'b0010, 1'b1, 1'b0, 32'h3C005A11};
    tv[7]  = '{4'b1111, 8'hE4, 32'h44332211, 4'b0000, 1'b0, 1'b1, 32'h3C002211};
    tv[8]  = '{4'b1111, 8'hE4, 32'h44332211, 4'b0100, 1'b1, 1'b0, 32'h3C002211};
    tv[9]  = '{4'b1111, 8'hE4, 32'h44332211, 4'b0000, 1'b0, 1'b1, 32'h3C332211};
    tv[10] = '{4'b1111, 8'hE4, 32'h44332211, 4'b1000, 1'b1, 1'b0, 32'h3C332211};
    tv[11] = '{4'b1111, 8'hE4, 32'h44332211, 4'b0000, 1'b0, 1'b1, 32'h44332211};
    tv[12] = '{4'b1111, 8'hE4, 32'h44332211, 4'b0001, 1'b1, 1'b0, 32'h44332211};
    tv[13] = '{4'b1111, 8'hE4, 32'h44332211, 4'b0000, 1'b0, 1'b1, 32'h44332211};
    // grant to 3, then 1001 gives 0 then 3 (pointer wrap)
    tv[14] = '{4'b1000, 8'hE4, 32'h55332211, 4'b1000, 1'b1, 1'b0, 32'h44332211};
    tv[15] = '{4'b1001, 8'hE4, 32'h55332266, 4'b0000, 1'b0, 1'b1, 32'h55332211};
    tv[16] = '{4'b1001, 8'hE4, 32'h55332266, 4'b0001, 1'b1, 1'b0, 32'h55332211};
    tv[17] = '{4'b1001, 8'hE4, 32'h55332266, 4'b0000, 1'b0, 1'b1, 32'h55332266};
    tv[18] = '{4'b1001, 8'hE4, 32'h77332266, 4'b1000, 1'b1, 1'b0, 32'h55332266};
    tv[19] = '{4'b0000, 8'hE4, 32'h77332266, 4'b0000, 1'b0, 1'b1, 32'h77332266};
    // req[2] raised only during COMMIT and dropped before IDLE: never granted
    tv[20] = '{4'b0001, 8'hE4, 32'h77332299, 4'b0001, 1'b1, 1'b0, 32'h77332266};
    tv[21] = '{4'b0100, 8'hE4, 32'h77332299, 4'b0000, 1'b0, 1'b1, 32'h77332299};
    tv[22] = '{4'b0000, 8'hE4, 32'h77332299, 4'b0000, 1'b0, 1'b0, 32'h77332299};
    // requester 1 changes addr/data in its gnt cycle: latched AB goes to q[1]
    tv[23] = '{4'b0010, 8'hE4, 32'h7733AB99, 4'b0010, 1'b1, 1'b0, 32'h77332299};
    tv[24] = '{4'b0000, 8'hE0, 32'h7733CD99, 4'b0000, 1'b0, 1'b1, 32'h7733AB99};
    tv[25] = '{4'b0000, 8'hE0, 32'h7733CD99, 4'b0000, 1'b0, 1'b0, 32'h7733AB99};

    async_reset = 1'b0;
    drive4(4'b0000, 8'h00, 32'h0);
    drive3(4'b0000, 8'h00, 32'h0);
    repeat (2) @(negedge clk);

    chk("reset.gnt",     64'(bus.gnt),     64'h0);
    chk("reset.busy",    64'(bus.busy),    64'h0);
    chk("reset.wr_done", 64'(bus.wr_done), 64'h0);
    chk("reset.err",     64'(bus.err),     64'h0);
    chk("reset.q",       64'(bus.q),       64'h0);
    async_reset = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive4(tv[i].req, tv[i].addr, tv[i].data);
      tick();
      chk($sformatf("vec%0d.gnt", i),     64'(bus.gnt),     64'(tv[i].gnt));
      chk($sformatf("vec%0d.busy", i),    64'(bus.busy),    64'(tv[i].busy));
      chk($sformatf("vec%0d.wr_done", i), 64'(bus.wr_done), 64'(tv[i].done));
      chk($sformatf("vec%0d.err", i),     64'(bus.err),     64'h0);
      chk($sformatf("vec%0d.q", i),       64'(bus.q),       64'(tv[i].q));
    end

    // NUM_REGS=3: valid write to q[2], then address 3 is out of range
    drive3(4'b0001, 8'h02, 32'h0000005C);
    tick();
    chk3("oor.gnt_valid", 4'b0001, 1'b1, 1'b0, 1'b0, 24'h000000);
    drive3(4'b0000, 8'h02, 32'h0000005C);
    tick();
    chk3("oor.commit_valid", 4'b0000, 1'b0, 1'b1, 1'b0, 24'h5C0000);
    drive3(4'b0001, 8'h03, 32'h000000EE);
    tick();
    chk3("oor.gnt_bad", 4'b0001, 1'b1, 1'b0, 1'b0, 24'h5C0000);
    drive3(4'b0000, 8'h03, 32'h000000EE);
    tick();
    chk3("oor.err_pulse", 4'b0000, 1'b0, 1'b0, 1'b1, 24'h5C0000);
    drive3(4'b0011, 8'h00, 32'h00000000);
    tick();
    chk3("oor.ptr_advanced", 4'b0010, 1'b1, 1'b0, 1'b0, 24'h5C0000);
    drive3(4'b0000, 8'h00, 32'h00000000);
    tick();
    chk3("oor.after", 4'b0000, 1'b0, 1'b1, 1'b0, 24'h5C0000);

    // asynchronous reset in the middle of a COMMIT for requester 1
    drive4(4'b0010, 8'hE8, 32'h7733A599);
    tick();
    chk("rst_mid.gnt_before",  64'(bus.gnt),  64'h2);
    chk("rst_mid.busy_before", 64'(bus.busy), 64'h1);
    #2;
    async_reset = 1'b0;
    #1;
    chk("rst_mid.gnt",  64'(bus.gnt),  64'h0);
    chk("rst_mid.busy", 64'(bus.busy), 64'h0);
    chk("rst_mid.q",    64'(bus.q),    64'h0);
    chk("rst_mid.q3",   64'(bus3.q),   64'h0);
    @(negedge clk);
    async_reset = 1'b1;
    drive4(4'b0000, 8'hE8, 32'h7733A599);
    tick();
    chk("rst_rel.q",       64'(bus.q),       64'h0);
    chk("rst_rel.wr_done", 64'(bus.wr_done), 64'h0);
    chk("rst_rel.gnt",     64'(bus.gnt),     64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
